// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: datapath widths, opcode values, memory-stage defaults
// and opcode classification helpers.
package mem_stage_pkg;

    localparam int unsigned OPCODE_WIDTH    = 8;
    localparam int unsigned IR_WIDTH        = 32;
    localparam int unsigned PC_WIDTH        = 16;
    localparam int unsigned REG_WIDTH       = 16;
    localparam int unsigned REG_IDX_WIDTH   = 4;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned LANES           = REG_WIDTH / BYTE_W;
    localparam int unsigned CNT_WIDTH       = 4;
    localparam int unsigned MEM_LAT_DEFAULT = 2;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D = 8'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDB   = 8'h3A;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h3B;
    localparam logic [OPCODE_WIDTH-1:0] OP_STB   = 8'h3C;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h3D;

    // Byte or word load
    function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LDB) || (op == OP_LDW);
    endfunction

    // Byte or word store
    function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_STB) || (op == OP_STW);
    endfunction

    // Any data-memory access
    function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Full-word access (as opposed to a single byte lane)
    function automatic logic is_word_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Data memory for the memory stage: word RAM with per-byte-lane write enables,
// one shared read/write address, combinational read, writes on the falling clock edge.
// Contents are not reset.
module mem_stage_dmem
    import mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 1024,
    localparam int unsigned ADDR_W    = $clog2(DMEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LANES-1:0]     be,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [REG_WIDTH-1:0] wdata,
    output logic [REG_WIDTH-1:0] rdata
);

    logic [REG_WIDTH-1:0] mem [DMEM_WORDS];

    // Lane-selective write
    always_ff @(negedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (be[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Performs LDB/LDW/STB/STW against an internal
// data memory with MEM_LAT-cycle access latency, stalling upstream combinationally
// while an access is pending; non-memory ops pass through in one cycle.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned word access fault).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic                     I_EX_Valid,
    input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
    input  logic [IR_WIDTH-1:0]      I_IR,
    input  logic [PC_WIDTH-1:0]      I_PC,
    input  logic [REG_IDX_WIDTH-1:0] I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]     I_DestValue,
    input  logic [REG_WIDTH-1:0]     I_MARValue,
    input  logic [REG_WIDTH-1:0]     I_MDRValue,
    input  logic                     I_RegWEn,
    output logic                     O_LOCK,
    output logic [OPCODE_WIDTH-1:0]  O_Opcode,
    output logic [IR_WIDTH-1:0]      O_IR,
    output logic [PC_WIDTH-1:0]      O_PC,
    output logic [REG_IDX_WIDTH-1:0] O_DestRegIdx,
    output logic [REG_WIDTH-1:0]     O_DestValue,
    output logic                     O_RegWEn,
    output logic                     O_MEM_Valid,
    output logic                     O_MemStallSignal,
    output logic                     O_RegWEn_Signal
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                     O_MisalignFault
`endif
);

    localparam int unsigned ADDR_W = $clog2(DMEM_WORDS);
    localparam int unsigned CMP_W  = CNT_WIDTH + 1;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 lane;
    logic                 mem_op_c;
    logic                 load_c;
    logic                 store_c;
    logic                 misalign_c;
    logic                 complete_c;
    logic                 regwen_c;
    logic                 dmem_we;
    logic [LANES-1:0]     dmem_be;
    logic [REG_WIDTH-1:0] dmem_wdata;
    logic [REG_WIDTH-1:0] dmem_rdata;
    logic [REG_WIDTH-1:0] load_data;
    logic [REG_WIDTH-1:0] result_c;
    logic                 unused_mar_hi;

    assign lane     = I_MARValue[0];
    assign mem_op_c = I_EX_Valid & is_mem_op(I_Opcode);
    assign load_c   = I_EX_Valid & is_load(I_Opcode);
    assign store_c  = I_EX_Valid & is_store(I_Opcode);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = mem_op_c & is_word_op(I_Opcode) & lane;
`else
    assign misalign_c = 1'b0;
`endif

    // Stall until the access has been waited on for MEM_LAT-1 edges
    assign O_MemStallSignal = mem_op_c & ~I_LOCK & (({1'b0, cnt} + CMP_W'(1)) < CMP_W'(MEM_LAT));
    assign complete_c       = ~I_LOCK & ~O_MemStallSignal;
    assign O_RegWEn_Signal  = I_EX_Valid & (I_RegWEn | is_load(I_Opcode));

    // Address bits above the memory depth wrap and are deliberately ignored
    assign unused_mar_hi = ^I_MARValue[REG_WIDTH-1:ADDR_W+1];

    // Wait-counter state register (0 = idle, >0 = waiting on access)
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Next wait count: hold under lock, count while stalling, clear otherwise
    always_comb begin
        cnt_nxt = cnt;
        if (!I_LOCK) begin
            cnt_nxt = O_MemStallSignal ? cnt + CNT_WIDTH'(1) : '0;
        end
    end

    // Memory controls and writeback value for the completing edge
    always_comb begin
        dmem_we    = 1'b0;
        dmem_be    = '0;
        dmem_wdata = I_MDRValue;
        load_data  = dmem_rdata;
        result_c   = I_DestValue;
        regwen_c   = 1'b0;

        if (complete_c && store_c && !misalign_c) begin
            dmem_we = 1'b1;
            if (is_word_op(I_Opcode)) begin
                dmem_be = '1;
            end else begin
                dmem_be    = LANES'(1) << lane;
                dmem_wdata = {LANES{I_MDRValue[BYTE_W-1:0]}};
            end
        end

        if (!is_word_op(I_Opcode)) begin
            load_data = REG_WIDTH'(lane ? dmem_rdata[2*BYTE_W-1:BYTE_W] : dmem_rdata[BYTE_W-1:0]);
        end

        if (load_c) begin
            result_c = misalign_c ? I_DestValue : load_data;
            regwen_c = ~misalign_c;
        end else if (!store_c) begin
            regwen_c = I_EX_Valid & I_RegWEn;
        end
    end

    // Output latch towards writeback
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            O_LOCK       <= 1'b1;
            O_MEM_Valid  <= 1'b0;
            O_RegWEn     <= 1'b0;
            O_Opcode     <= '0;
            O_IR         <= '0;
            O_PC         <= '0;
            O_DestRegIdx <= '0;
            O_DestValue  <= '0;
        end else if (I_LOCK) begin
            O_LOCK <= 1'b1;
        end else begin
            O_LOCK <= 1'b0;
            if (O_MemStallSignal) begin
                O_MEM_Valid <= 1'b0;
                O_RegWEn    <= 1'b0;
            end else begin
                O_MEM_Valid  <= I_EX_Valid;
                O_RegWEn     <= regwen_c;
                O_Opcode     <= I_Opcode;
                O_IR         <= I_IR;
                O_PC         <= I_PC;
                O_DestRegIdx <= I_DestRegIdx;
                O_DestValue  <= result_c;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Sticky fault on any completed misaligned word access
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            O_MisalignFault <= 1'b0;
        end else if (complete_c && misalign_c) begin
            O_MisalignFault <= 1'b1;
        end
    end
`endif

    mem_stage_dmem #(
        .DMEM_WORDS(DMEM_WORDS)
    ) u_dmem (
        .clk  (I_CLOCK),
        .we   (dmem_we),
        .be   (dmem_be),
        .addr (I_MARValue[ADDR_W:1]),
        .wdata(dmem_wdata),
        .rdata(dmem_rdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (MEM_LAT=1 and MEM_LAT=3) driven by directed
// and random instruction streams; expectations come from a byte-addressed memory model
// and are queued per instance, a monitor pops them whenever an instance presents output.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int NI = 2;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;
    localparam int MEM_BYTES = 2048;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] ir;
        logic [15:0] pc;
        logic [3:0]  idx;
        logic [15:0] dest;
        bit          chk_dest;
        logic        regwen;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst       [NI];
    logic        lock      [NI];
    logic        ex_valid  [NI];
    logic        regwen_in [NI];
    logic [7:0]  opcode    [NI];
    logic [31:0] ir        [NI];
    logic [15:0] pc        [NI];
    logic [3:0]  didx      [NI];
    logic [15:0] dval      [NI];
    logic [15:0] mar       [NI];
    logic [15:0] mdr       [NI];

    logic        o_lock    [NI];
    logic [7:0]  o_opcode  [NI];
    logic [31:0] o_ir      [NI];
    logic [15:0] o_pc      [NI];
    logic [3:0]  o_idx     [NI];
    logic [15:0] o_dest    [NI];
    logic        o_regwen  [NI];
    logic        o_valid   [NI];
    logic        o_stall   [NI];
    logic        o_rws     [NI];
`ifdef MEM_ALIGN_CHECK_EN
    logic        o_fault   [NI];
`endif

    exp_t sb0[$];
    exp_t sb1[$];
    logic [7:0] ref_mem [NI][MEM_BYTES];
    logic       fault_ref [NI];
    int errors = 0;
    int checks = 0;
    exp_t mon_e;
    bit   mon_ok;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_stage #(
            .MEM_LAT   (g == 0 ? LAT0 : LAT1),
            .DMEM_WORDS(1024)
        ) u_dut (
            .I_CLOCK         (clk),
            .I_RESET         (rst[g]),
            .I_LOCK          (lock[g]),
            .I_EX_Valid      (ex_valid[g]),
            .I_Opcode        (opcode[g]),
            .I_IR            (ir[g]),
            .I_PC            (pc[g]),
            .I_DestRegIdx    (didx[g]),
            .I_DestValue     (dval[g]),
            .I_MARValue      (mar[g]),
            .I_MDRValue      (mdr[g]),
            .I_RegWEn        (regwen_in[g]),
            .O_LOCK          (o_lock[g]),
            .O_Opcode        (o_opcode[g]),
            .O_IR            (o_ir[g]),
            .O_PC            (o_pc[g]),
            .O_DestRegIdx    (o_idx[g]),
            .O_DestValue     (o_dest[g]),
            .O_RegWEn        (o_regwen[g]),
            .O_MEM_Valid     (o_valid[g]),
            .O_MemStallSignal(o_stall[g]),
            .O_RegWEn_Signal (o_rws[g])
`ifdef MEM_ALIGN_CHECK_EN
            ,
            .O_MisalignFault (o_fault[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s[inst%0d] @%0t: got %h expected %h", nm, k, $time, act, exp_v);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic bit tb_is_mem(input logic [7:0] op);
        return op inside {OP_LDB, OP_LDW, OP_STB, OP_STW};
    endfunction

    // Reference behaviour: byte-addressed little-endian memory, wraps modulo its size
    function automatic exp_t model(input int k, input logic [7:0] op, input logic [15:0] a,
                                   input logic [15:0] d, input logic [15:0] dv, input logic rw,
                                   input logic [31:0] i_ir, input logic [15:0] i_pc, input logic [3:0] i_idx);
        exp_t e;
        int ba = int'(a) % MEM_BYTES;
        int wb = ba - (ba % 2);
        bit mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (op == OP_LDW || op == OP_STW) && (ba % 2 == 1);
        if (mis) fault_ref[k] = 1'b1;
`endif
        e.op = op; e.ir = i_ir; e.pc = i_pc; e.idx = i_idx;
        e.chk_dest = !mis; e.dest = dv; e.regwen = rw;
        if (op == OP_LDW) begin
            e.dest = {ref_mem[k][wb+1], ref_mem[k][wb]};
            e.regwen = !mis;
        end else if (op == OP_LDB) begin
            e.dest = {8'h00, ref_mem[k][ba]};
            e.regwen = 1'b1;
        end else if (op == OP_STW) begin
            if (!mis) begin
                ref_mem[k][wb]   = d[7:0];
                ref_mem[k][wb+1] = d[15:8];
            end
            e.regwen = 1'b0; e.chk_dest = 1'b0;
        end else if (op == OP_STB) begin
            ref_mem[k][ba] = d[7:0];
            e.regwen = 1'b0; e.chk_dest = 1'b0;
        end
        e.fault = fault_ref[k];
        return e;
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic set_inputs(input int k, input logic [7:0] op, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] dv, input logic rw);
        opcode[k] = op; mar[k] = a; mdr[k] = d; dval[k] = dv; regwen_in[k] = rw;
        didx[k] = 4'($urandom); pc[k] = 16'($urandom); ir[k] = $urandom;
        ex_valid[k] = 1'b1;
    endtask

    // Present one instruction, hold it through any stall, return just after it completes
    task automatic issue(input int k, input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] dv, input logic rw);
        int st = 0;
        @(posedge clk);
        set_inputs(k, op, a, d, dv, rw);
        push(k, model(k, op, a, d, dv, rw, ir[k], pc[k], didx[k]));
        #1;
        chk("regwen_hint", k, 32'(o_rws[k]), 32'(rw | (op == OP_LDB) | (op == OP_LDW)));
        while (o_stall[k] && st <= 20) begin
            st++;
            @(posedge clk);
            #1;
            chk("valid_during_stall", k, 32'(o_valid[k]), 32'(0));
        end
        chk("stall_cycles", k, 32'(st), 32'(tb_is_mem(op) ? lat_of(k) - 1 : 0));
        @(negedge clk);
        #1;
        ex_valid[k] = 1'b0;
    endtask

    // Monitor: every presented, unlocked output pops and checks one expectation
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (o_valid[k] === 1'b1 && o_lock[k] === 1'b0) begin
                mon_ok = 1'b0;
                if (k == 0 && sb0.size() > 0) begin mon_e = sb0.pop_front(); mon_ok = 1'b1; end
                if (k == 1 && sb1.size() > 0) begin mon_e = sb1.pop_front(); mon_ok = 1'b1; end
                chk("output_expected", k, 32'(mon_ok), 32'(1));
                if (mon_ok) begin
                    chk("opcode", k, 32'(o_opcode[k]), 32'(mon_e.op));
                    chk("ir", k, o_ir[k], mon_e.ir);
                    chk("pc", k, 32'(o_pc[k]), 32'(mon_e.pc));
                    chk("dest_idx", k, 32'(o_idx[k]), 32'(mon_e.idx));
                    chk("regwen", k, 32'(o_regwen[k]), 32'(mon_e.regwen));
                    if (mon_e.chk_dest) chk("dest_value", k, 32'(o_dest[k]), 32'(mon_e.dest));
`ifdef MEM_ALIGN_CHECK_EN
                    chk("misalign_fault", k, 32'(o_fault[k]), 32'(mon_e.fault));
`endif
                end
            end
        end
    end

    task automatic random_phase(input int k, input int n);
        logic [7:0] op;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_LDB;
                1: op = OP_LDW;
                2: op = OP_STB;
                3: op = OP_STW;
                4: op = OP_ADD_D;
                default: op = 8'h05;
            endcase
            a = 16'(($urandom & 32'hF800) | (32'($urandom_range(0, 15)) << 1) | 32'($urandom_range(0, 1)));
            issue(k, op, a, 16'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [15:0] saved;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b0; lock[k] = 1'b0; ex_valid[k] = 1'b0; regwen_in[k] = 1'b0;
            opcode[k] = '0; ir[k] = '0; pc[k] = '0; didx[k] = '0; dval[k] = '0; mar[k] = '0; mdr[k] = '0;
            fault_ref[k] = 1'b0;
            for (int b = 0; b < MEM_BYTES; b++) ref_mem[k][b] = 8'h00;
        end
        #1;
        rst[0] = 1'b1; rst[1] = 1'b1;
        #2;
        for (int k = 0; k < NI; k++) begin
            chk("reset_lock", k, 32'(o_lock[k]), 32'(1));
            chk("reset_valid", k, 32'(o_valid[k]), 32'(0));
            chk("reset_regwen", k, 32'(o_regwen[k]), 32'(0));
            chk("reset_dest", k, 32'(o_dest[k]), 32'(0));
            chk("reset_pc", k, 32'(o_pc[k]), 32'(0));
        end
        @(posedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Give every word of the working pool a known value
        for (int k = 0; k < NI; k++)
            for (int w = 0; w < 16; w++)
                issue(k, OP_STW, 16'(w * 2), 16'($urandom), 16'($urandom), 1'b0);

        // Single-cycle memory: store/load round trip and byte-lane merge
        issue(0, OP_STW, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        issue(0, OP_LDW, 16'h0010, 16'h0000, 16'h0000, 1'b0);
        chk("plan_ldw_beef", 0, 32'(o_dest[0]), 32'h0000BEEF);
        chk("plan_ldw_regwen", 0, 32'(o_regwen[0]), 32'(1));
        issue(0, OP_STB, 16'h0011, 16'h0012, 16'h0000, 1'b0);
        issue(0, OP_LDW, 16'h0010, 16'h0000, 16'h0000, 1'b0);
        chk("plan_stb_merge", 0, 32'(o_dest[0]), 32'h000012EF);
        issue(0, OP_LDB, 16'h0011, 16'h0000, 16'h0000, 1'b0);
        chk("plan_ldb_hi", 0, 32'(o_dest[0]), 32'h00000012);
        issue(0, OP_LDB, 16'hF810, 16'h0000, 16'h0000, 1'b0);
        chk("ldb_lo_wrap", 0, 32'(o_dest[0]), 32'h000000EF);

        // Lock holds a completed result, then lets the next op through
        issue(0, OP_ADD_D, 16'h0000, 16'h0000, 16'h5A5A, 1'b1);
        @(posedge clk);
        lock[0] = 1'b1;
        set_inputs(0, OP_ADD_D, 16'h0000, 16'h0000, 16'h1111, 1'b1);
        push(0, model(0, OP_ADD_D, 16'h0000, 16'h0000, 16'h1111, 1'b1, ir[0], pc[0], didx[0]));
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("lock_o_lock", 0, 32'(o_lock[0]), 32'(1));
            chk("lock_hold_dest", 0, 32'(o_dest[0]), 32'h5A5A);
            chk("lock_hold_valid", 0, 32'(o_valid[0]), 32'(1));
        end
        @(posedge clk);
        lock[0] = 1'b0;
        @(negedge clk);
        #1;
        ex_valid[0] = 1'b0;
        chk("unlock_o_lock", 0, 32'(o_lock[0]), 32'(0));
        chk("unlock_dest", 0, 32'(o_dest[0]), 32'h1111);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word accesses fault and leave memory untouched
        issue(0, OP_LDW, 16'h0003, 16'h0000, 16'h0000, 1'b0);
        chk("misalign_fault_set", 0, 32'(o_fault[0]), 32'(1));
        chk("misalign_regwen", 0, 32'(o_regwen[0]), 32'(0));
        issue(0, OP_STW, 16'h0003, 16'hAAAA, 16'h0000, 1'b0);
        issue(0, OP_LDW, 16'h0002, 16'h0000, 16'h0000, 1'b0);
        chk("misalign_sticky", 0, 32'(o_fault[0]), 32'(1));
`endif

        // Multi-cycle memory: load latency and non-memory pass-through
        issue(1, OP_LDW, 16'h0010, 16'h0000, 16'h0000, 1'b0);
        issue(1, OP_ADD_D, 16'h0000, 16'h0000, 16'h0007, 1'b1);
        chk("add_dest", 1, 32'(o_dest[1]), 32'h0007);
        chk("add_regwen", 1, 32'(o_regwen[1]), 32'(1));

        // Lock during a pending access freezes the wait count
        @(posedge clk);
        set_inputs(1, OP_LDW, 16'h0004, 16'h0000, 16'h0000, 1'b0);
        push(1, model(1, OP_LDW, 16'h0004, 16'h0000, 16'h0000, 1'b0, ir[1], pc[1], didx[1]));
        #1 chk("lk_stall0", 1, 32'(o_stall[1]), 32'(1));
        @(posedge clk);
        #1 chk("lk_stall1", 1, 32'(o_stall[1]), 32'(1));
        lock[1] = 1'b1;
        #1 chk("lk_stall_masked", 1, 32'(o_stall[1]), 32'(0));
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("lk_o_lock", 1, 32'(o_lock[1]), 32'(1));
            chk("lk_valid_held", 1, 32'(o_valid[1]), 32'(0));
        end
        @(posedge clk);
        lock[1] = 1'b0;
        #1 chk("lk_stall_resume", 1, 32'(o_stall[1]), 32'(1));
        @(posedge clk);
        #1 chk("lk_stall_done", 1, 32'(o_stall[1]), 32'(0));
        @(negedge clk);
        #1;
        ex_valid[1] = 1'b0;
        chk("lk_complete", 1, 32'(o_valid[1]), 32'(1));

        // Reset in the middle of a store abandons it
        saved = {ref_mem[1][11], ref_mem[1][10]};
        @(posedge clk);
        set_inputs(1, OP_STW, 16'h000A, ~saved, 16'h0000, 1'b0);
        @(negedge clk);
        #1 chk("rst_mid_stall", 1, 32'(o_stall[1]), 32'(1));
        rst[1] = 1'b1;
        ex_valid[1] = 1'b0;
        #1;
        chk("rst_mid_lock", 1, 32'(o_lock[1]), 32'(1));
        chk("rst_mid_valid", 1, 32'(o_valid[1]), 32'(0));
        chk("rst_mid_regwen", 1, 32'(o_regwen[1]), 32'(0));
        chk("rst_mid_dest", 1, 32'(o_dest[1]), 32'(0));
        chk("rst_mid_opcode", 1, 32'(o_opcode[1]), 32'(0));
        @(posedge clk);
        rst[1] = 1'b0;
        fault_ref[1] = 1'b0;
        issue(1, OP_LDW, 16'h000A, 16'h0000, 16'h0000, 1'b0);
        chk("rst_old_word", 1, 32'(o_dest[1]), 32'(saved));

        random_phase(0, 60);
        random_phase(1, 60);

        repeat (3) @(posedge clk);
        #1;
        chk("sb0_drained", 0, 32'(sb0.size()), 32'(0));
        chk("sb1_drained", 1, 32'(sb1.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the scalar pipeline: consumes the execute-stage output latch, performs LDB/LDW/STB/STW against an internal byte-lane data memory with configurable access latency, and presents results to writeback. It freezes the upstream stages with a combinational stall while a multi-cycle access is in progress. Non-memory operations pass through in one cycle.

## Interface
- MEM_LAT, 2, cycles per data-memory access (1..15)
- DMEM_WORDS, 1024, depth of data memory in REG_WIDTH-bit words (power of two); ADDR_W = log2(DMEM_WORDS)
- I_CLOCK  in  1  pipeline clock; all state updates on falling edge
- I_RESET  in  1  reset, asynchronous, active-high
- I_LOCK  in  1  pipeline lock; high = hold
- I_EX_Valid  in  1  execute latch holds a real instruction
- I_Opcode / I_IR / I_PC  in  OPCODE_WIDTH / IR_WIDTH / PC_WIDTH  instruction identity
- I_DestRegIdx  in  4  destination register
- I_DestValue  in  REG_WIDTH  ALU result
- I_MARValue  in  REG_WIDTH  byte address
- I_MDRValue  in  REG_WIDTH  store data
- I_RegWEn  in  1  ALU op writes a register
- O_LOCK, O_Opcode, O_IR, O_PC, O_DestRegIdx  out  registered copies
- O_DestValue  out  REG_WIDTH  ALU result or load data
- O_RegWEn  out  1  writeback enable
- O_MEM_Valid  out  1  output latch holds a completed instruction
- O_MemStallSignal  out  1  combinational; upstream holds inputs while high
- O_RegWEn_Signal  out  1  combinational dependency hint = I_EX_Valid & (I_RegWEn | load)

## Operation
- mem_op = I_EX_Valid & opcode in {LDB,LDW,STB,STW}; load = LDB|LDW.
- Wait counter cnt (4 bits). States: IDLE (cnt==0), WAIT (cnt>0).
- O_MemStallSignal = mem_op & ~I_LOCK & (cnt < MEM_LAT-1). MEM_LAT=1 never stalls.
- Falling edge, I_LOCK low: if stall, cnt+1, O_MEM_Valid<=0, O_RegWEn<=0, no memory write. Else cnt<=0, access performed, O_MEM_Valid<=I_EX_Valid, identity fields registered.
- Word index = I_MARValue[ADDR_W:1]; higher bits ignored (wraps modulo DMEM_WORDS).
- LDW: O_DestValue = word; LDB: byte lane I_MARValue[0] (0=low), zero-extended; O_RegWEn=1.
- STW: write full word; STB: write I_MDRValue[7:0] into selected lane only, other lane unchanged; O_RegWEn=0.
- Non-memory valid op: O_DestValue=I_DestValue, O_RegWEn=I_RegWEn, one cycle, no stall.
- I_EX_Valid low: bubble, no access, cnt unchanged at 0.
- I_LOCK high: O_LOCK<=1, all other outputs and cnt hold, no memory write.
- Memory contents zero at simulation start; not cleared by reset.

## Timing
- Reset (async): cnt=0, O_LOCK=1, O_MEM_Valid=0, O_RegWEn=0, all data/identity outputs 0; reset mid-access abandons it with no write.
- Latency: non-memory 1 edge; memory op MEM_LAT edges, stall high for first MEM_LAT-1.
- Store write and load read occur on the same completing edge; a load directly after a store to the same word returns the new data.
- Inputs must be stable while O_MemStallSignal high; changes are undefined.

## Configuration
- MEM_ALIGN_CHECK_EN defined: LDW/STW with I_MARValue[0]=1 performs no access, completes with O_RegWEn=0, and sets sticky output O_MisalignFault (1 bit, cleared only by reset). Undefined: port absent, address bit 0 ignored for word ops.

## Structure
- Opcode values, OPCODE/IR/PC/REG_WIDTH stay in the shared global definitions header; add MEM_LAT default there.
- One sub-module: mem_stage_dmem (byte-lane-writable word RAM, single read/write port, combinational read).

## Test plan
- MEM_LAT=1; STW MAR=0x0010 MDR=0xBEEF, then LDW MAR=0x0010 -> O_DestValue=0xBEEF, O_RegWEn=1, no stall.
- STB MAR=0x0011 MDR=0x0012 over word 0xBEEF, LDW 0x0010 -> 0x12EF; LDB 0x0011 -> 0x0012.
- MEM_LAT=3; LDW valid -> stall high 2 cycles, O_MEM_Valid low 2 edges then high on 3rd.
- ADD_D with I_DestValue=0x0007 -> next edge O_DestValue=0x0007, O_RegWEn=1, stall never high.
- MEM_LAT=3, assert I_RESET after first stall cycle of STW -> outputs reset values, later LDW shows old word.
- MEM_ALIGN_CHECK_EN; LDW MAR=0x0003 -> O_MisalignFault=1, O_RegWEn=0, memory unchanged.
